// File: rtl/flow_table_matcher.sv
// Masked flow lookup ahead of the OpenFlow action processor.
// Linear table walk, one entry per cycle, lowest index wins.
`timescale 1ns/1ps

`ifndef OF_ACTION_DATA_WIDTH
`define OF_ACTION_DATA_WIDTH 64
`endif
`ifndef OF_ACTION_CTRL_WIDTH
`define OF_ACTION_CTRL_WIDTH 8
`endif
`ifndef OF_DST_PORT_POS
`define OF_DST_PORT_POS 0
`endif

module flow_table_matcher #(
    parameter int KEY_WIDTH         = 64,
    parameter int ACTION_DATA_WIDTH = `OF_ACTION_DATA_WIDTH,
    parameter int ACTION_CTRL_WIDTH = `OF_ACTION_CTRL_WIDTH,
    parameter int NUM_ENTRIES       = 8,
    parameter logic [ACTION_CTRL_WIDTH-1:0] DEFAULT_ACTION_CTRL = '0,
    localparam int IDX_W            = $clog2(NUM_ENTRIES)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [KEY_WIDTH-1:0]         key_in,
    input  logic                         key_valid,
    output logic                         key_rdy,
    input  logic                         tbl_wr_en,
    input  logic [IDX_W-1:0]             tbl_wr_addr,
    input  logic [KEY_WIDTH-1:0]         tbl_wr_key,
    input  logic [KEY_WIDTH-1:0]         tbl_wr_mask,
    input  logic [ACTION_DATA_WIDTH-1:0] tbl_wr_action_data,
    input  logic [ACTION_CTRL_WIDTH-1:0] tbl_wr_action_ctrl,
    input  logic                         tbl_wr_entry_valid,
    output logic [ACTION_DATA_WIDTH-1:0] action_data_bus,
    output logic [ACTION_CTRL_WIDTH-1:0] action_ctrl_bus,
    output logic                         action_valid,
    input  logic                         action_rdy,
    output logic [31:0]                  hit_count,
    output logic [31:0]                  miss_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        EMIT   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic             armed;

    logic [KEY_WIDTH-1:0] key_q;

    logic [KEY_WIDTH-1:0]         tbl_key  [NUM_ENTRIES];
    logic [KEY_WIDTH-1:0]         tbl_mask [NUM_ENTRIES];
    logic [ACTION_DATA_WIDTH-1:0] tbl_data [NUM_ENTRIES];
    logic [ACTION_CTRL_WIDTH-1:0] tbl_ctrl [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]       tbl_valid;

    logic [ACTION_DATA_WIDTH-1:0] pend_data;
    logic [ACTION_CTRL_WIDTH-1:0] pend_ctrl;
    logic [ACTION_DATA_WIDTH-1:0] last_data;
    logic [ACTION_CTRL_WIDTH-1:0] last_ctrl;

    logic entry_hit;
    logic last_entry;
    logic load_key;
    logic take_hit;
    logic take_miss;
    logic fire;

    // Compare the current entry; table registers give pre-write contents.
    always_comb begin
        entry_hit  = tbl_valid[idx] &&
                     (((key_q ^ tbl_key[idx]) & tbl_mask[idx]) == '0);
        last_entry = (idx == IDX_W'(NUM_ENTRIES - 1));
    end

    // Next-state and strobe decode for the lookup FSM.
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        load_key     = 1'b0;
        take_hit     = 1'b0;
        take_miss    = 1'b0;
        fire         = 1'b0;
        key_rdy      = 1'b0;
        action_valid = 1'b0;
        unique case (state)
            IDLE: begin
                key_rdy = armed;
                if (armed && key_valid) begin
                    load_key   = 1'b1;
                    idx_next   = '0;
                    state_next = SEARCH;
                end
            end
            SEARCH: begin
                if (entry_hit) begin
                    take_hit   = 1'b1;
                    state_next = EMIT;
                end else if (last_entry) begin
                    take_miss  = 1'b1;
                    state_next = EMIT;
                end else begin
                    idx_next = idx + IDX_W'(1);
                end
            end
            EMIT: begin
                if (action_rdy) begin
                    fire         = 1'b1;
                    action_valid = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, search index and post-reset arming of key_rdy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            armed <= 1'b1;
        end
    end

    // Table storage; writes land at the edge, in any FSM state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tbl_valid <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tbl_key[i]  <= '0;
                tbl_mask[i] <= '0;
                tbl_data[i] <= '0;
                tbl_ctrl[i] <= '0;
            end
        end else if (tbl_wr_en) begin
            tbl_valid[tbl_wr_addr] <= tbl_wr_entry_valid;
            tbl_key[tbl_wr_addr]   <= tbl_wr_key;
            tbl_mask[tbl_wr_addr]  <= tbl_wr_mask;
            tbl_data[tbl_wr_addr]  <= tbl_wr_action_data;
            tbl_ctrl[tbl_wr_addr]  <= tbl_wr_action_ctrl;
        end
    end

    // Key capture, pending action, and last emitted action.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_q     <= '0;
            pend_data <= '0;
            pend_ctrl <= '0;
            last_data <= '0;
            last_ctrl <= '0;
        end else begin
            if (load_key) begin
                key_q <= key_in;
            end
            if (take_hit) begin
                pend_data <= tbl_data[idx];
                pend_ctrl <= tbl_ctrl[idx];
            end else if (take_miss) begin
                pend_data <= '0;
                pend_ctrl <= DEFAULT_ACTION_CTRL;
            end
            if (fire) begin
                last_data <= pend_data;
                last_ctrl <= pend_ctrl;
            end
        end
    end

    // Saturating hit/miss statistics.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (take_hit && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (take_miss && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end

    // Pending action is shown while waiting, else the last one emitted.
    always_comb begin
        action_data_bus = last_data;
        action_ctrl_bus = last_ctrl;
        if (state == EMIT) begin
            action_data_bus = pend_data;
            action_ctrl_bus = pend_ctrl;
        end
    end

endmodule

// File: tb/tb_flow_table_matcher.sv
// Scoreboard bench for flow_table_matcher.
// Directed keys; a monitor pops expected actions on each strobe.
`timescale 1ns/1ps

module tb_flow_table_matcher;

    localparam int KW  = 64;
    localparam int ADW = 64;
    localparam int ACW = 8;
    localparam int N   = 8;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [KW-1:0]  key_in = '0;
    logic           key_valid = 1'b0;
    logic           key_rdy;
    logic           tbl_wr_en = 1'b0;
    logic [2:0]     tbl_wr_addr = '0;
    logic [KW-1:0]  tbl_wr_key = '0;
    logic [KW-1:0]  tbl_wr_mask = '0;
    logic [ADW-1:0] tbl_wr_action_data = '0;
    logic [ACW-1:0] tbl_wr_action_ctrl = '0;
    logic           tbl_wr_entry_valid = 1'b0;
    logic [ADW-1:0] action_data_bus;
    logic [ACW-1:0] action_ctrl_bus;
    logic           action_valid;
    logic           action_rdy = 1'b1;
    logic [31:0]    hit_count;
    logic [31:0]    miss_count;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  ctrl;
        int          lat;
        time         t0;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   exp_pulses = 0;

    flow_table_matcher #(
        .KEY_WIDTH(KW),
        .ACTION_DATA_WIDTH(ADW),
        .ACTION_CTRL_WIDTH(ACW),
        .NUM_ENTRIES(N),
        .DEFAULT_ACTION_CTRL(8'h00)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .key_in(key_in),
        .key_valid(key_valid),
        .key_rdy(key_rdy),
        .tbl_wr_en(tbl_wr_en),
        .tbl_wr_addr(tbl_wr_addr),
        .tbl_wr_key(tbl_wr_key),
        .tbl_wr_mask(tbl_wr_mask),
        .tbl_wr_action_data(tbl_wr_action_data),
        .tbl_wr_action_ctrl(tbl_wr_action_ctrl),
        .tbl_wr_entry_valid(tbl_wr_entry_valid),
        .action_data_bus(action_data_bus),
        .action_ctrl_bus(action_ctrl_bus),
        .action_valid(action_valid),
        .action_rdy(action_rdy),
        .hit_count(hit_count),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [63:0] k,
                      input logic [63:0] m, input logic [63:0] d,
                      input logic [7:0] c, input logic v);
        @(negedge clk);
        tbl_wr_en          = 1'b1;
        tbl_wr_addr        = a;
        tbl_wr_key         = k;
        tbl_wr_mask        = m;
        tbl_wr_action_data = d;
        tbl_wr_action_ctrl = c;
        tbl_wr_entry_valid = v;
        @(posedge clk);
        #1 tbl_wr_en = 1'b0;
    endtask

    // lat: expected cycle of action_valid counting the accept cycle as 0
    task automatic send_key(input logic [63:0] k, input logic [63:0] d,
                            input logic [7:0] c, input int lat,
                            input bit push);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (key_rdy !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (key_rdy !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL key_rdy_timeout: got %b expected 1", key_rdy);
            return;
        end
        key_in    = k;
        key_valid = 1'b1;
        @(posedge clk);
        e.data = d;
        e.ctrl = c;
        e.lat  = lat;
        e.t0   = $time;
        if (push) begin
            sb.push_back(e);
            exp_pulses++;
        end
        #1 key_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || key_rdy !== 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(sb.size()), 64'd0);
    endtask

    // Pop and compare one expected action per strobe.
    always @(negedge clk) begin
        exp_t e;
        int   k;
        if (action_valid === 1'b1) begin
            pulses++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_action: got data %h ctrl %h expected none",
                         action_data_bus, action_ctrl_bus);
            end else begin
                e = sb.pop_front();
                chk("action_data", action_data_bus, e.data);
                chk("action_ctrl", 64'(action_ctrl_bus), 64'(e.ctrl));
                if (e.lat >= 0) begin
                    k = int'(($time - e.t0 - 5) / 10) + 1;
                    chk("latency", 64'(k), 64'(e.lat));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_key_rdy", 64'(key_rdy), 64'd0);
        chk("rst_valid", 64'(action_valid), 64'd0);
        chk("rst_data", action_data_bus, 64'd0);
        chk("rst_ctrl", 64'(action_ctrl_bus), 64'd0);
        chk("rst_hits", 64'(hit_count), 64'd0);
        chk("rst_miss", 64'(miss_count), 64'd0);
        rst_n = 1'b1;

        // empty table miss
        send_key(64'h1, 64'h0, 8'h00, 9, 1);
        drain();
        chk("t1_miss", 64'(miss_count), 64'd1);
        chk("t1_hits", 64'(hit_count), 64'd0);

        // exact hit on entry 3, dst port 4
        wr(3'd3, 64'hAABB, ONES, 64'h0004, 8'h01, 1'b1);
        send_key(64'hAABB, 64'h0004, 8'h01, 5, 1);
        drain();
        chk("t2_hits", 64'(hit_count), 64'd1);
        chk("t2_hold_data", action_data_bus, 64'h0004);
        chk("t2_dst_port", 64'(action_data_bus[15:0]), 64'h0004);

        // overlapping masked entries: lowest index wins
        wr(3'd2, 64'h1200, 64'hFF00, 64'h0022, 8'h01, 1'b1);
        wr(3'd5, 64'h1255, 64'hFF00, 64'h0055, 8'h01, 1'b1);
        send_key(64'h12AB, 64'h0022, 8'h01, 4, 1);
        drain();
        chk("t3_hits", 64'(hit_count), 64'd2);
        chk("t3_pulses", 64'(pulses), 64'd3);

        // downstream back-pressure holds the action
        action_rdy = 1'b0;
        send_key(64'hAABB, 64'h0004, 8'h01, -1, 1);
        repeat (6) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(action_valid), 64'd0);
            chk("stall_key_rdy", 64'(key_rdy), 64'd0);
            chk("stall_data", action_data_bus, 64'h0004);
            chk("stall_ctrl", 64'(action_ctrl_bus), 64'h01);
        end
        @(posedge clk);
        #1 action_rdy = 1'b1;
        @(negedge clk);
        chk("release_valid", 64'(action_valid), 64'd1);
        @(negedge clk);
        chk("release_key_rdy", 64'(key_rdy), 64'd1);
        chk("release_single", 64'(action_valid), 64'd0);
        drain();
        chk("t4_hits", 64'(hit_count), 64'd3);

        // entry 6 written while the search sits at idx 1
        send_key(64'h6666, 64'h0066, 8'h01, 8, 1);
        @(negedge clk);
        wr(3'd6, 64'h6666, ONES, 64'h0066, 8'h01, 1'b1);
        drain();
        chk("t5_hits", 64'(hit_count), 64'd4);

        // entry 0 cleared in the cycle it is compared
        wr(3'd0, 64'h7777, ONES, 64'h0077, 8'h01, 1'b1);
        send_key(64'h7777, 64'h0077, 8'h01, 2, 1);
        wr(3'd0, 64'h7777, ONES, 64'h0077, 8'h01, 1'b0);
        drain();
        chk("t6_hits", 64'(hit_count), 64'd5);
        send_key(64'h7777, 64'h0, 8'h00, 9, 1);
        drain();
        chk("t6_miss", 64'(miss_count), 64'd2);

        // reset mid-search abandons the key and empties the table
        send_key(64'hAABB, 64'h0, 8'h00, -1, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_valid", 64'(action_valid), 64'd0);
            chk("mid_rst_key_rdy", 64'(key_rdy), 64'd0);
        end
        chk("mid_rst_hits", 64'(hit_count), 64'd0);
        chk("mid_rst_miss", 64'(miss_count), 64'd0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        send_key(64'hAABB, 64'h0, 8'h00, 9, 1);
        drain();
        chk("t7_miss", 64'(miss_count), 64'd1);
        chk("t7_hits", 64'(hit_count), 64'd0);

        repeat (4) @(negedge clk);
        chk("total_pulses", 64'(pulses), 64'(exp_pulses));
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
